// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Slot 0 registers the (possibly inverted) operands; each later slot resolves one
// BLOCK-bit slice of the sum by selecting between two precomputed slice sums.
module pipelined_csa_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BLOCK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    // WIDTH must be a multiple of BLOCK.
    localparam int unsigned NSTAGE = WIDTH / BLOCK;

    // Slot k holds the carry into slice k and sum bits below slice k.
    // Slot NSTAGE is the output register.
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] b_q   [NSTAGE];
    logic [WIDTH-1:0] a_d   [NSTAGE];
    logic [WIDTH-1:0] b_d   [NSTAGE];
    logic [WIDTH-1:0] sum_q [NSTAGE+1];
    logic [WIDTH-1:0] sum_d [NSTAGE+1];
    logic             cy_q  [NSTAGE+1];
    logic             cy_d  [NSTAGE+1];
    logic             vld_q [NSTAGE+1];
    logic             vld_d [NSTAGE+1];
    logic             ovf_q;
    logic             ovf_d;

    logic [BLOCK-1:0] slice_a;
    logic [BLOCK-1:0] slice_b;
    logic [BLOCK:0]   res0;
    logic [BLOCK:0]   res1;
    logic [BLOCK:0]   res_sel;
    logic             en;

    // Whole pipe advances unless a presented result is being held.
    assign en        = !vld_q[NSTAGE] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[NSTAGE];
    assign sum       = sum_q[NSTAGE];
    assign c_out     = cy_q[NSTAGE];
    assign overflow  = ovf_q;

    // Next-state for every slot: operand capture, then one carry-select slice per slot.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        res0    = '0;
        res1    = '0;
        res_sel = '0;
        a_d[0]   = a;
        b_d[0]   = sub ? ~b : b;
        cy_d[0]  = sub ? 1'b1 : c_in;
        sum_d[0] = '0;
        vld_d[0] = in_valid;
        for (int k = 0; k < NSTAGE; k++) begin
            slice_a = a_q[k][k*BLOCK +: BLOCK];
            slice_b = b_q[k][k*BLOCK +: BLOCK];
            res0    = {1'b0, slice_a} + {1'b0, slice_b};
            res1    = {1'b0, slice_a} + {1'b0, slice_b} + (BLOCK+1)'(1);
            res_sel = cy_q[k] ? res1 : res0;
            if (k + 1 < NSTAGE) begin
                a_d[k+1] = a_q[k];
                b_d[k+1] = b_q[k];
            end
            sum_d[k+1]                    = sum_q[k];
            sum_d[k+1][k*BLOCK +: BLOCK]  = res_sel[BLOCK-1:0];
            cy_d[k+1]                     = res_sel[BLOCK];
            vld_d[k+1]                    = vld_q[k];
        end
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        ovf_d = cy_d[NSTAGE] ^ (sum_d[NSTAGE][WIDTH-1] ^ a_q[NSTAGE-1][WIDTH-1]
                                ^ b_q[NSTAGE-1][WIDTH-1]);
    end

    // Pipeline registers; data only loads for valid beats so idle outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= NSTAGE; k++) begin
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k <= NSTAGE; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    sum_q[k] <= sum_d[k];
                    cy_q[k]  <= cy_d[k];
                end
            end
            for (int k = 0; k < NSTAGE; k++) begin
                if (vld_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                end
            end
            if (vld_d[NSTAGE]) begin
                ovf_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Directed self-checking bench for pipelined_csa_adder (64/16 and 32/8 instances).
module tb_pipelined_csa_adder;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] sum;
    logic        c_out;
    logic        overflow;

    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        c_in32 = 1'b0;
    logic        sub32 = 1'b0;
    logic        out_valid32;
    logic [31:0] sum32;
    logic        c_out32;
    logic        overflow32;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipelined_csa_adder #(.WIDTH(64), .BLOCK(16)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    pipelined_csa_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .c_in(c_in32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(1'b1), .sum(sum32), .c_out(c_out32), .overflow(overflow32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One isolated beat on the 64-bit instance, checked at its exact latency.
    task automatic run64(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                         input logic tc, input logic ts, input logic [63:0] es,
                         input logic ec, input logic eo);
        @(negedge clk);
        a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NS - 1) @(negedge clk);
        check({tag, "_early"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, {63'd0, c_out}, {63'd0, ec});
        check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
    endtask

    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic ec, input logic eo);
        @(negedge clk);
        a32 = ta; b32 = tb_; c_in32 = tc; sub32 = ts; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (NS - 1) @(negedge clk);
        @(negedge clk);
        check({tag, "_vld"}, {63'd0, out_valid32}, 64'd1);
        check({tag, "_sum"}, {32'd0, sum32}, {32'd0, es});
        check({tag, "_cout"}, {63'd0, c_out32}, {63'd0, ec});
        check({tag, "_ovf"}, {63'd0, overflow32}, {63'd0, eo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        logic stale;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout_ovf", {62'd0, c_out, overflow}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run64("add_basic", 64'd1, 64'd1, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0);
        run64("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0);
        run64("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run64("sub_pos_cin_ign", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        run64("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run64("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Back-to-back beats.
        @(negedge clk);
        a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; c_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        a = 64'h0000_0000_FFFF_FFFF; b = 64'h0000_0000_0000_00BA; c_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NS - 2) @(negedge clk);
        @(negedge clk);
        check("b2b_0_vld", {63'd0, out_valid}, 64'd1);
        check("b2b_0_sum", sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check("b2b_0_cout", {63'd0, c_out}, 64'd0);
        @(negedge clk);
        check("b2b_1_vld", {63'd0, out_valid}, 64'd1);
        check("b2b_1_sum", sum, 64'h0000_0001_0000_00BA);
        check("b2b_1_cout", {63'd0, c_out}, 64'd0);

        // Bubble between two beats; idle output holds the previous result.
        @(negedge clk);
        a = 64'h10; b = 64'h20; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        a = 64'h100; b = 64'h1; sub = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NS - 3) @(negedge clk);
        @(negedge clk);
        check("bub_0_sum", sum, 64'h30);
        @(negedge clk);
        check("bub_gap_vld", {63'd0, out_valid}, 64'd0);
        check("bub_gap_hold", sum, 64'h30);
        @(negedge clk);
        check("bub_1_vld", {63'd0, out_valid}, 64'd1);
        check("bub_1_sum", sum, 64'hFF);
        check("bub_1_cout", {63'd0, c_out}, 64'd1);

        // Backpressure: six beats offered while downstream is stalled.
        sub = 1'b0; c_in = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (sent < 6) begin
                a = 64'h10 + 64'(sent); b = 64'h100; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) sent++;
        end
        check("bp_accepted", 64'(sent), 64'd5);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_vld", {63'd0, out_valid}, 64'd1);
        check("bp_sum0", sum, 64'h110);
        repeat (2) @(negedge clk);
        check("bp_hold_sum", sum, 64'h110);
        check("bp_hold_vld", {63'd0, out_valid}, 64'd1);

        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (got < 6 && out_valid) begin
                check($sformatf("bp_out%0d", got), sum, 64'h110 + 64'(got));
                got++;
            end
            if (sent < 6) begin
                a = 64'h10 + 64'(sent); b = 64'h100; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) sent++;
        end
        check("bp_count", 64'(got), 64'd6);
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Reset with three beats in flight.
        @(negedge clk);
        a = 64'd1; b = 64'd2; in_valid = 1'b1;
        @(negedge clk);
        a = 64'd3;
        @(negedge clk);
        a = 64'd4;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_vld", {63'd0, out_valid}, 64'd0);
        check("mid_rst_sum", sum, 64'd0);
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("mid_rst_no_stale", {63'd0, stale}, 64'd0);

        // 32-bit / 8-bit slice configuration.
        run32("w32_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        run32("w32_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run32("w32_sub_neg", 32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run32("w32_sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run32("w32_slices", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101,
              1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
